beta_recursion_unit: RTL and testbench

Parametrised backward-recursion (beta) engine for the max-log-MAP decoder's 8-state constituent trellis. It loads an initial beta vector and consumes one branch-metric pair per accepted step. For each step it computes eight new state metrics with add-compare-select and saturating arithmetic, and stores every step's vector in an internal K-deep buffer. The buffer is read back by the LLR stage. It sits between the branch-metric unit and the LLR combiner, replacing the fixed-width, fixed-depth beta block.

---
 rtl/beta_recursion_unit.sv | 146 ++++++++++++++
 tb/tb_beta_recursion_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/beta_recursion_unit.sv
// beta_recursion_unit: 8-state backward (beta) recursion for max-log-MAP.
// Loads an initial beta vector, then runs one add-compare-select step per
// accepted branch-metric pair. Each step's vector is stored in a K-deep
// buffer that the LLR stage reads back.
// Optional build macro: BETA_NORM_EN subtracts state 0 from every state
// after each step, so state 0 stays at 0 and the metrics cannot drift.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; start loads init_beta and clears cnt
// RUN   | one ACS step and one buffer write per accepted gamma pair
// DONE  | window complete, done pulses for one cycle, back to IDLE
module beta_recursion_unit #(
  parameter int N  = 12,
  parameter int K  = 8,
  parameter int AW = $clog2(K)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [8*N-1:0]  init_beta,
  input  logic            gm_valid,
  output logic            gm_ready,
  input  logic [N-1:0]    gamma_a,
  input  logic [N-1:0]    gamma_b,
  output logic [8*N-1:0]  beta_cur,
  output logic            busy,
  output logic            done,
  input  logic [AW-1:0]   rd_addr,
  output logic [8*N-1:0]  rd_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q;
  logic [8*N-1:0]  beta_q;
  logic [8*N-1:0]  beta_nxt;
  logic            accept;
  logic            last_step;

  logic [N-1:0]    pa_v  [8];
  logic [N-1:0]    pb_v  [8];
  logic [N-1:0]    acs_v [8];

  // Sized to the full address space so any rd_addr indexes a real entry.
  logic [8*N-1:0]  buf_mem [2**AW];

  // Sign-extend by one bit so sums and differences of two metrics cannot overflow.
  function automatic logic signed [N:0] ext(input logic [N-1:0] v);
    return {v[N-1], v};
  endfunction

  // Clamp an (N+1)-bit signed value into the N-bit signed range.
  function automatic logic [N-1:0] sat(input logic signed [N:0] x);
    if (x[N] != x[N-1])
      return x[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    else
      return x[N-1:0];
  endfunction

  assign accept    = (state_q == S_RUN) && gm_valid;
  assign last_step = (cnt_q == AW'(K-1));
  assign beta_cur  = beta_q;

  // Next-state decode and status outputs, all decoded from the current state.
  always_comb begin
    state_d  = state_q;
    busy     = 1'b0;
    gm_ready = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        busy     = 1'b1;
        gm_ready = 1'b1;
        if (accept && last_step) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Add-compare-select on the trellis; predecessors of s are 2s and 2s+1 (mod 8).
  always_comb begin
    pa_v     = '{default: '0};
    pb_v     = '{default: '0};
    acs_v    = '{default: '0};
    beta_nxt = '0;
    for (int s = 0; s < 8; s++) begin
      pa_v[s]  = sat(ext(beta_q[((2*s)   % 8)*N +: N]) + ext(gamma_a));
      pb_v[s]  = sat(ext(beta_q[((2*s+1) % 8)*N +: N]) + ext(gamma_b));
      acs_v[s] = ($signed(pa_v[s]) >= $signed(pb_v[s])) ? pa_v[s] : pb_v[s];
    end
    for (int s = 0; s < 8; s++) begin
`ifdef BETA_NORM_EN
      beta_nxt[s*N +: N] = sat(ext(acs_v[s]) - ext(acs_v[0]));
`else
      beta_nxt[s*N +: N] = acs_v[s];
`endif
    end
  end

  // State register, step counter, beta vector and registered read port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      beta_q  <= '0;
      rd_data <= '0;
    end else begin
      state_q <= state_d;
      rd_data <= buf_mem[rd_addr];
      case (state_q)
        S_IDLE: begin
          if (start) begin
            beta_q <= init_beta;
            cnt_q  <= '0;
          end
        end
        S_RUN: begin
          if (gm_valid) begin
            beta_q <= beta_nxt;
            if (!last_step) cnt_q <= cnt_q + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Step buffer; deliberately not reset so previous windows survive rst.
  always_ff @(posedge clk) begin
    if (accept) buf_mem[cnt_q] <= beta_nxt;
  end

endmodule

// File: tb/tb_beta_recursion_unit.sv
// Testbench for beta_recursion_unit: scoreboard of expected beta vectors
// from an integer reference model, plus buffer readback and status checks.
module tb_beta_recursion_unit;
  localparam int N  = 12;
  localparam int K  = 8;
  localparam int AW = $clog2(K);
  localparam int W  = 8*N;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  init_beta;
  logic          gm_valid;
  logic          gm_ready;
  logic [N-1:0]  gamma_a;
  logic [N-1:0]  gamma_b;
  logic [W-1:0]  beta_cur;
  logic          busy;
  logic          done;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  logic [W-1:0] exp_q [$];
  logic [W-1:0] exp_buf [K];
  logic [W-1:0] model_cur;

  beta_recursion_unit #(.N(N), .K(K)) dut (
    .clk(clk), .rst(rst), .start(start), .init_beta(init_beta),
    .gm_valid(gm_valid), .gm_ready(gm_ready), .gamma_a(gamma_a),
    .gamma_b(gamma_b), .beta_cur(beta_cur), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int x);
    if (x > 2**(N-1) - 1) return 2**(N-1) - 1;
    if (x < -(2**(N-1)))  return -(2**(N-1));
    return x;
  endfunction

  function automatic int lane(input logic [W-1:0] v, input int s);
    logic signed [N-1:0] t;
    t = v[s*N +: N];
    return int'(t);
  endfunction

  function automatic logic [W-1:0] fill(input int v);
    logic [W-1:0] r;
    for (int s = 0; s < 8; s++) r[s*N +: N] = N'(v);
    return r;
  endfunction

  function automatic logic [W-1:0] model_step(input logic [W-1:0] b, input int ga, input int gb);
    int nv [8];
    int pa, pb, n0;
    logic [W-1:0] r;
    for (int s = 0; s < 8; s++) begin
      pa = clampi(lane(b, (2*s) % 8) + ga);
      pb = clampi(lane(b, (2*s+1) % 8) + gb);
      nv[s] = (pa >= pb) ? pa : pb;
    end
`ifdef BETA_NORM_EN
    n0 = nv[0];
    for (int s = 0; s < 8; s++) nv[s] = clampi(nv[s] - n0);
`else
    n0 = 0;
`endif
    for (int s = 0; s < 8; s++) r[s*N +: N] = N'(nv[s] + n0 - n0);
    return r;
  endfunction

  task automatic do_start(input logic [W-1:0] init);
    init_beta = init;
    start = 1'b1;
    done_cnt = 0;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("start_busy", W'(busy), W'(1));
    check_eq("start_ready", W'(gm_ready), W'(1));
    check_eq("start_beta", beta_cur, init);
    model_cur = init;
  endtask

  task automatic do_step(input int ga, input int gb, input int k);
    logic [W-1:0] e;
    check_eq("ready_pre", W'(gm_ready), W'(1));
    gm_valid = 1'b1;
    gamma_a = N'(ga);
    gamma_b = N'(gb);
    e = model_step(model_cur, ga, gb);
    exp_q.push_back(e);
    exp_buf[k] = e;
    model_cur = e;
    @(posedge clk); #1;
    gm_valid = 1'b0;
    check_eq($sformatf("step%0d", k), beta_cur, exp_q.pop_front());
  endtask

  task automatic idle_gap(input int cycles, input bit poke_start);
    for (int i = 0; i < cycles; i++) begin
      if (poke_start && i == 0) begin
        start = 1'b1;
        init_beta = fill(-7);
      end
      gamma_a = N'(999);
      gamma_b = N'(-999);
      @(posedge clk); #1;
      start = 1'b0;
      check_eq("stall_beta", beta_cur, model_cur);
      check_eq("stall_busy", W'(busy), W'(1));
    end
  endtask

  task automatic readback();
    for (int a = 0; a < K; a++) begin
      rd_addr = AW'(a);
      @(posedge clk); #1;
      check_eq($sformatf("rd%0d", a), rd_data, exp_buf[a]);
    end
  endtask

  task automatic run_window(input logic [W-1:0] init, input int ga, input int gb,
                            input int dga, input int dgb, input int gap);
    do_start(init);
    for (int k = 0; k < K; k++) begin
      do_step(ga + k*dga, gb + k*dgb, k);
      if (gap > 0 && k < K-1) idle_gap(gap, k == 2);
    end
    check_eq("done_hi", W'(done), W'(1));
    check_eq("done_busy", W'(busy), W'(0));
    check_eq("done_ready", W'(gm_ready), W'(0));
    @(posedge clk); #1;
    check_eq("done_lo", W'(done), W'(0));
    readback();
    check_eq("done_count", W'(done_cnt), W'(1));
  endtask

  initial begin
    logic [W-1:0] conn;
    rst = 1'b1; start = 1'b0; init_beta = '0; gm_valid = 1'b0;
    gamma_a = '0; gamma_b = '0; rd_addr = '0;
    #12;
    check_eq("rst_beta", beta_cur, '0);
    check_eq("rst_busy", W'(busy), W'(0));
    check_eq("rst_done", W'(done), W'(0));
    check_eq("rst_ready", W'(gm_ready), W'(0));
    check_eq("rst_rd", rd_data, '0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Uniform: step k gives 2(k+1) on every state without normalisation.
    run_window(fill(0), 2, 2, 0, 0, 0);
`ifdef BETA_NORM_EN
    check_eq("uni_end", beta_cur, fill(0));
`else
    check_eq("uni_end", beta_cur, fill(16));
`endif

    // Connectivity: lane s initialised to 10s.
    for (int s = 0; s < 8; s++) conn[s*N +: N] = N'(10*s);
    run_window(conn, 0, 5, 0, 0, 0);
`ifndef BETA_NORM_EN
    check_eq("conn_first", exp_buf[0], {N'(75), N'(55), N'(35), N'(15), N'(75), N'(55), N'(35), N'(15)});
`endif

    // Saturation at both rails.
    run_window(fill(2047), 100, 100, 0, 0, 0);
    run_window(fill(-2048), -100, -100, 0, 0, 0);

    // Stalls of 3 cycles with an ignored start during RUN, varied gammas.
    run_window(conn, -20, 13, 7, -5, 3);

    // Mid-run reset after step 3, asserted away from the clock edge.
    do_start(fill(5));
    for (int k = 0; k < 3; k++) do_step(3 - k, k + 1, k);
    #3 rst = 1'b1;
    #1;
    check_eq("mrst_beta", beta_cur, '0);
    check_eq("mrst_busy", W'(busy), W'(0));
    check_eq("mrst_done", W'(done), W'(0));
    check_eq("mrst_ready", W'(gm_ready), W'(0));
    check_eq("mrst_rd", rd_data, '0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check_eq("mrst_idle_busy", W'(busy), W'(0));

    // Fresh window after reset overwrites the buffer from entry 0.
    run_window(fill(-40), 9, -3, -2, 4, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
